// File: rtl/risc_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, runs a one-outstanding req/ack fetch,
// and buffers address-tagged words for decode. Optional perf counters: RISC_FETCH_PERF_EN.
module risc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [INSTR_W-1:0]         imem_data,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [INSTR_W-1:0]         instr,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                fetched_cnt,
    output logic [31:0]                flushed_cnt
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t             state, state_next;
    logic               run_q;
    logic [ADDR_W-1:0]  fetch_pc, fetch_pc_next;
    logic [ADDR_W-1:0]  pend_pc, pend_pc_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic               req, enq, deq, flush, discard;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        pend_pc_next  = pend_pc;
        req           = 1'b0;
        enq           = 1'b0;
        flush         = 1'b0;
        discard       = 1'b0;
        case (state)
            RUN: begin
                req = run_q & (cnt < FULL);
                if (redirect) begin
                    flush = 1'b1;
                    if (req & ~imem_ack) begin
                        // Request already on the bus must complete before the new PC can be issued.
                        state_next   = DRAIN;
                        pend_pc_next = redirect_pc;
                    end else begin
                        fetch_pc_next = redirect_pc;
                        discard       = req & imem_ack;
                    end
                end else if (req & imem_ack) begin
                    enq           = 1'b1;
                    fetch_pc_next = fetch_pc + STEP;
                end
            end
            DRAIN: begin
                req   = 1'b1;
                flush = redirect;
                if (redirect) begin
                    pend_pc_next = redirect_pc;
                end
                if (imem_ack) begin
                    discard       = 1'b1;
                    fetch_pc_next = redirect ? redirect_pc : pend_pc;
                    state_next    = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign deq         = instr_valid & instr_ready & ~flush;
    assign imem_req    = req;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (cnt != '0);
    assign instr       = q_instr[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];
    assign count       = cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= RUN;
            run_q    <= 1'b0;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            run_q    <= 1'b1;
            fetch_pc <= fetch_pc_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                case ({enq, deq})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        pend_pc <= pend_pc_next;
        if (enq) begin
            q_instr[wr_ptr] <= imem_data;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end

`ifdef RISC_FETCH_PERF_EN
    logic [31:0] fetched_q, flushed_q, flush_amt;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // A flush drops every queued entry plus the response that arrived alongside it, if any.
    assign flush_amt = (flush ? 32'(cnt) : 32'd0) + (discard ? 32'd1 : 32'd0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= sat_add(fetched_q, {31'd0, enq});
            flushed_q <= sat_add(flushed_q, flush_amt);
        end
    end

    assign fetched_cnt = fetched_q;
    assign flushed_cnt = flushed_q;
`else
    logic unused_perf;
    assign unused_perf = discard;
    assign fetched_cnt = '0;
    assign flushed_cnt = '0;
`endif

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Bench for risc_fetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations (second instance covers PC wrap).
module tb_risc_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imem_ack = 1'b0, redirect = 1'b0, instr_ready = 1'b0;
    logic [31:0] imem_data = 32'h0, redirect_pc = 32'h0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc, fetched_cnt, flushed_cnt;
    logic [2:0]  count;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_instr_pc, w_fetched, w_flushed;
    logic [2:0]  w_count;

    int errors = 0;
    int checks = 0;
    int data_seq = 0;

    always #5 CLK = ~CLK;

    risc_fetch_unit dut (
        .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .count(count),
        .fetched_cnt(fetched_cnt), .flushed_cnt(flushed_cnt)
    );

    risc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RST(RST), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(1'b1), .imem_data(32'h0BAD_F00D), .redirect(1'b0),
        .redirect_pc(32'h0), .instr_valid(w_valid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_instr_pc), .count(w_count),
        .fetched_cnt(w_fetched), .flushed_cnt(w_flushed)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    bit          m_run, m_drain;
    logic [31:0] m_pc, m_pend;
    longint      m_fetched, m_flushed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    // Compare against the model, then advance it using the inputs the next edge will see.
    task automatic model_step();
        int   n;
        bit   exp_req, xfer;
        ent_t e;
        if (!RST) begin
            m_run = 0; m_drain = 0; m_pc = 32'h0; m_pend = 32'h0;
            mq.delete(); m_fetched = 0; m_flushed = 0;
        end
        n       = mq.size();
        exp_req = m_drain || (m_run && n < 4);
        chk("m_imem_req", 32'(imem_req), 32'(exp_req));
        chk("m_imem_addr", imem_addr, m_pc);
        chk("m_instr_valid", 32'(instr_valid), 32'(n != 0));
        chk("m_count", 32'(count), 32'(n));
        if (n != 0) begin
            chk("m_instr", instr, mq[0].instr);
            chk("m_instr_pc", instr_pc, mq[0].pc);
        end
`ifdef RISC_FETCH_PERF_EN
        chk("m_fetched_cnt", fetched_cnt, 32'(m_fetched));
        chk("m_flushed_cnt", flushed_cnt, 32'(m_flushed));
`else
        chk("m_fetched_cnt", fetched_cnt, 32'd0);
        chk("m_flushed_cnt", flushed_cnt, 32'd0);
`endif
        if (RST) begin
            xfer = exp_req && imem_ack;
            if (redirect) begin
                m_flushed = sat(m_flushed + n);
                mq.delete();
                if (m_drain) begin
                    m_pend = redirect_pc;
                    if (imem_ack) begin
                        m_flushed = sat(m_flushed + 1);
                        m_pc = m_pend;
                        m_drain = 0;
                    end
                end else if (exp_req && !imem_ack) begin
                    m_drain = 1;
                    m_pend = redirect_pc;
                end else begin
                    if (xfer) m_flushed = sat(m_flushed + 1);
                    m_pc = redirect_pc;
                end
            end else if (m_drain) begin
                if (imem_ack) begin
                    m_flushed = sat(m_flushed + 1);
                    m_pc = m_pend;
                    m_drain = 0;
                end
            end else begin
                if (n != 0 && instr_ready) void'(mq.pop_front());
                if (xfer) begin
                    e.instr = imem_data;
                    e.pc    = m_pc;
                    mq.push_back(e);
                    m_fetched = sat(m_fetched + 1);
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = 1;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        model_step();
        @(posedge CLK);
        #1;
        data_seq++;
        imem_data = 32'hC0DE_0000 | 32'(data_seq);
    endtask

    task automatic restart(input bit ack, input bit rdy);
        RST = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        tick();
        RST = 1'b1;
        imem_ack = ack;
        instr_ready = rdy;
    endtask

    logic [31:0] fl0;

    initial begin
        tick();
        tick();
        // Fill with decode stalled; wrap instance streams from 0xFFFFFFFC
        restart(1'b1, 1'b0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_fetched", fetched_cnt, 32'd0);
        chk("rst_flushed", flushed_cnt, 32'd0);
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_req", 32'(w_req), 32'd0);
        tick();
        chk("fill_addr0", imem_addr, 32'h0);
        chk("fill_req0", 32'(imem_req), 32'd1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick();
        chk("fill_addr1", imem_addr, 32'h4);
        chk("wrap_addr1", w_addr, 32'h0);
        chk("wrap_pc0", w_instr_pc, 32'hFFFF_FFFC);
        tick();
        chk("fill_addr2", imem_addr, 32'h8);
        chk("wrap_pc1", w_instr_pc, 32'h0);
        chk("wrap_count", 32'(w_count), 32'd1);
        tick();
        chk("fill_addr3", imem_addr, 32'hC);
        tick();
        chk("full_count", 32'(count), 32'd4);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_head_pc", instr_pc, 32'h0);
        tick();
        chk("full_hold_count", 32'(count), 32'd4);

        // Streaming: one instruction per cycle, occupancy 1
        restart(1'b1, 1'b1);
        tick();
        tick();
        chk("stream_count", 32'(count), 32'd1);
        chk("stream_pc0", instr_pc, 32'h0);
        tick();
        chk("stream_pc1", instr_pc, 32'h4);
        tick();
        chk("stream_pc2", instr_pc, 32'h8);
        chk("stream_count2", 32'(count), 32'd1);

        // Redirect while a fetch is pending: drain, discard, refetch
        restart(1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk("drain_pre_addr", imem_addr, 32'h8);
        fl0 = flushed_cnt;
        imem_ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("drain_addr_a", imem_addr, 32'h8);
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("drain_addr_b", imem_addr, 32'h8);
        tick();
        chk("drain_addr_c", imem_addr, 32'h8);
        imem_ack = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("refetch_addr", imem_addr, 32'h100);
        chk("refetch_valid", 32'(instr_valid), 32'd0);
`ifdef RISC_FETCH_PERF_EN
        chk("drain_flushed", flushed_cnt, fl0 + 32'd3);
`endif
        tick();
        imem_ack = 1'b1;
        imem_data = 32'h1234_5678;
        chk("refetch_wait_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("refetch_instr", instr, 32'h1234_5678);
        chk("refetch_pc", instr_pc, 32'h100);

        // Redirect coinciding with req&ack and a dequeue at count=3
        tick();
        tick();
        chk("flush_pre_count", 32'(count), 32'd3);
        chk("flush_pre_addr", imem_addr, 32'h10C);
        fl0 = flushed_cnt;
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_addr", imem_addr, 32'h200);
        chk("flush_valid", 32'(instr_valid), 32'd0);
`ifdef RISC_FETCH_PERF_EN
        chk("flush_flushed", flushed_cnt, fl0 + 32'd4);
`endif

        // Asynchronous reset mid-cycle with two entries queued
        imem_ack = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0;
        chk("arst_pre_count", 32'(count), 32'd2);
        #1 RST = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        tick();
        RST = 1'b1;
        imem_ack = 1'b1;
        tick();
        chk("arst_first_addr", imem_addr, 32'h0);
        chk("arst_first_req", 32'(imem_req), 32'd1);
        tick();
        chk("arst_first_pc", instr_pc, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
